// File: rtl/cache_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the cache bus arbiter.
// Latency: none, wires only.
// Backpressure: carried by mem_bus_valid/mem_bus_ready and req_bus_valid/req_bus_ready.
interface cache_bus_arbiter_if #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 4
);
  localparam int LINE = DATA_WIDTH * (2 ** OFFSET_LENGTH);

  // requester side (index 0 = I-cache, index 1 = D-cache)
  logic [1:0]              req_command_valid;
  logic [1:0]              req_command_store;
  logic [1:0]              req_command_rready;
  logic [2*ADDR_WIDTH-1:0] req_command_addr;
  logic [2*LINE-1:0]       req_data_to_bus;
  logic [LINE-1:0]         req_data_from_bus;
  logic [1:0]              req_bus_valid;
  logic [1:0]              req_bus_ready;
  logic [1:0]              req_invalidate;
  logic [ADDR_WIDTH-1:0]   req_invalidate_addr;

  // memory side
  logic                    mem_command_valid;
  logic                    mem_command_store;
  logic                    mem_command_rready;
  logic [ADDR_WIDTH-1:0]   mem_command_addr;
  logic [LINE-1:0]         mem_data_to_bus;
  logic [LINE-1:0]         mem_data_from_bus;
  logic                    mem_bus_valid;
  logic                    mem_bus_ready;

  // arbiter view
  modport slave (
    input  req_command_valid, req_command_store, req_command_rready,
           req_command_addr, req_data_to_bus,
           mem_data_from_bus, mem_bus_valid, mem_bus_ready,
    output req_data_from_bus, req_bus_valid, req_bus_ready,
           req_invalidate, req_invalidate_addr,
           mem_command_valid, mem_command_store, mem_command_rready,
           mem_command_addr, mem_data_to_bus
  );

  // environment view: requesters plus memory
  modport master (
    output req_command_valid, req_command_store, req_command_rready,
           req_command_addr, req_data_to_bus,
           mem_data_from_bus, mem_bus_valid, mem_bus_ready,
    input  req_data_from_bus, req_bus_valid, req_bus_ready,
           req_invalidate, req_invalidate_addr,
           mem_command_valid, mem_command_store, mem_command_rready,
           mem_command_addr, mem_data_to_bus
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache (0) and D-cache (1).
// Latency: command reaches memory one cycle after grant; responses pass through combinationally.
// Backpressure: the owner waits on mem_bus_valid (fill) or mem_bus_ready (write-back); others wait in IDLE.
module cache_bus_arbiter #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  cache_bus_arbiter_if.slave  bus,
  output logic                grant_owner,
  output logic                busy
);
  localparam int LINE = DATA_WIDTH * (2 ** OFFSET_LENGTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // clears the word-offset bits so memory always sees a line-aligned address
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_LENGTH){1'b1}}, {OFFSET_LENGTH{1'b0}}};

  logic [0:0]            state;
  logic                  last_owner;  // drives round-robin, starts at 1 so req0 wins first
  logic                  owner;       // requester of the current or most recent grant
  logic                  cmd_store;
  logic                  cmd_rready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LINE-1:0]       cmd_line;
  logic [1:0]            inv_q;

  logic                  any_req;
  logic                  winner;
  logic                  in_busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LINE-1:0]       win_line;

  // pick the requester to serve: the only one asking, or the one not served last
  always_comb begin
    any_req  = |bus.req_command_valid;
    winner   = (&bus.req_command_valid) ? ~last_owner : bus.req_command_valid[1];
    win_addr = winner ? bus.req_command_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                      : bus.req_command_addr[ADDR_WIDTH-1:0];
    win_line = winner ? bus.req_data_to_bus[2*LINE-1:LINE]
                      : bus.req_data_to_bus[LINE-1:0];
    in_busy  = (state == BUSY);
    // only the response that matches the transaction direction can finish it
    done     = in_busy && (cmd_store ? bus.mem_bus_ready : bus.mem_bus_valid);
  end

  // state machine and command capture; requester inputs are sampled only at grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      cmd_store  <= 1'b0;
      cmd_rready <= 1'b0;
      cmd_addr   <= '0;
      cmd_line   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            last_owner <= winner;
            owner      <= winner;
            cmd_store  <= bus.req_command_store[winner];
            cmd_rready <= bus.req_command_rready[winner];
            cmd_addr   <= win_addr & LINE_MASK;
            cmd_line   <= win_line;
          end
        end
        default: begin
          // going back to IDLE here guarantees one idle cycle before the next grant
          if (done) state <= IDLE;
        end
      endcase
    end
  end

  // a finished write-back invalidates the same line in the other cache on the next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_q <= 2'b00;
    end else begin
      inv_q <= (done && cmd_store) ? (owner ? 2'b01 : 2'b10) : 2'b00;
    end
  end

  // memory command comes only from captured registers and is silent outside BUSY
  always_comb begin
    bus.mem_command_valid  = in_busy;
    bus.mem_command_store  = in_busy & cmd_store;
    bus.mem_command_rready = in_busy & cmd_rready;
    bus.mem_command_addr   = in_busy ? cmd_addr : '0;
    bus.mem_data_to_bus    = cmd_line;
  end

  // responses are routed to the owner only; the non-owner never sees valid/ready
  always_comb begin
    bus.req_bus_valid       = 2'b00;
    bus.req_bus_ready       = 2'b00;
    bus.req_data_from_bus   = '0;
    if (in_busy && !cmd_store) begin
      bus.req_bus_valid[owner] = bus.mem_bus_valid;
      bus.req_data_from_bus    = bus.mem_data_from_bus;
    end
    if (in_busy && cmd_store) begin
      bus.req_bus_ready[owner] = bus.mem_bus_ready;
    end
    bus.req_invalidate      = inv_q;
    bus.req_invalidate_addr = (|inv_q) ? cmd_addr : '0;
    grant_owner             = owner;
    busy                    = in_busy;
  end
endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width.
REQ-003 SHALL have parameter OFFSET_LENGTH, default 4, log2 words per line; LINE = DATA_WIDTH*2**OFFSET_LENGTH (1024 at defaults).
REQ-004 SHALL have ports, with requester 0 as the I-cache and requester 1 as the D-cache:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- req_command_valid  in  2  per-requester command request.
- req_command_store  in  2  1 = line write-back, 0 = line fill.
- req_command_rready  in  2  requester ready for fill data.
- req_command_addr  in  2*ADDR_WIDTH  requester r uses bits [r*ADDR_WIDTH +: ADDR_WIDTH].
- req_data_to_bus  in  2*LINE  write-back line, indexed per requester.
- req_data_from_bus  out  LINE  fill data, broadcast to both requesters.
- req_bus_valid  out  2  fill data valid for requester r.
- req_bus_ready  out  2  write-back accepted for requester r.
- req_invalidate  out  2  one-cycle invalidate pulse to requester r.
- req_invalidate_addr  out  ADDR_WIDTH  invalidate line address.
- mem_command_valid, mem_command_store, mem_command_rready  out  1 each  memory command.
- mem_command_addr  out  ADDR_WIDTH  memory line address.
- mem_data_to_bus  out  LINE  write data.
- mem_data_from_bus  in  LINE  read data.
- mem_bus_valid  in  1  read data valid.
- mem_bus_ready  in  1  write accepted.
- grant_owner  out  1  current or last owner.
- busy  out  1  transaction in flight.

Function
REQ-005 SHALL implement two states: IDLE and BUSY.
REQ-006 In IDLE with exactly one req_command_valid bit set, SHALL grant that requester and enter BUSY at the next edge.
REQ-007 In IDLE with both bits set, SHALL grant the requester that is not last_owner (round-robin); last_owner SHALL update on each grant.
REQ-008 At grant, SHALL register store, rready, addr (low OFFSET_LENGTH bits forced to 0) and the owner's write line; mem_* outputs SHALL be driven only from these registers.
REQ-009 In BUSY, mem_command_valid SHALL be 1; in IDLE, all mem_command_* outputs SHALL be 0.
REQ-010 BUSY read (store=0): req_bus_valid[owner] SHALL equal mem_bus_valid combinationally; req_data_from_bus SHALL equal mem_data_from_bus; BUSY SHALL go to IDLE on the edge where mem_bus_valid=1.
REQ-011 BUSY write (store=1): req_bus_ready[owner] SHALL equal mem_bus_ready combinationally; BUSY SHALL go to IDLE on the edge where mem_bus_ready=1.
REQ-012 During a read, mem_bus_ready SHALL be ignored; during a write, mem_bus_valid SHALL be ignored. In IDLE, both SHALL be ignored.
REQ-013 The non-owner's req_bus_valid and req_bus_ready SHALL stay 0 at all times.
REQ-014 After completion, SHALL spend at least one cycle in IDLE before the next grant; no back-to-back grant in the completion cycle.
REQ-015 On write-back completion by requester r, SHALL pulse req_invalidate[1-r] for exactly one cycle starting the next cycle, with req_invalidate_addr = the registered line address.
REQ-016 Changes to req_* inputs while BUSY SHALL NOT alter the registered command.
REQ-017 busy SHALL be 1 exactly in BUSY.

Reset
REQ-018 While reset=0, SHALL force IDLE, last_owner=1, and zero all registered command fields; all outputs SHALL be 0, effective immediately without a clock.
REQ-019 If reset is asserted mid-transaction, SHALL abandon the transaction and drop mem_command_valid asynchronously; after release, SHALL NOT resume the transaction.

Verification
REQ-020 Single fill: req0 valid, addr 0x1234, store=0 -> next cycle mem_command_addr=0x1230, rready=1; mem_bus_valid plus data 0xA5.. -> req_bus_valid=2'b01 in the same cycle, data broadcast, IDLE next cycle.
REQ-021 Contention: both requesters valid out of reset -> req0 granted first; req1 still valid after completion -> req1 granted after one IDLE cycle; third contention -> req0.
REQ-022 D-cache write-back addr 0x8000: mem_command_store=1 and mem_data_to_bus = req1 line; mem_bus_ready -> req_bus_ready=2'b10; next cycle req_invalidate=2'b01, addr 0x8000, for 1 cycle.
REQ-023 Spurious responses: mem_bus_valid=1 in IDLE -> no req_bus_valid; mem_bus_valid=1 during a write -> still BUSY, no req_bus_valid.
REQ-024 Async reset while BUSY read -> mem_command_valid=0 before the next edge; after release with no requests, it stays 0.
REQ-025 Input change in BUSY: req0 addr switches 0x40 to 0x80 mid-fill -> mem_command_addr stays 0x40 until completion.
